// File: rtl/control_flow_sequencer_if.sv
// Decoder-to-sequencer instruction channel for control_flow_sequencer.
// The decoder is the master and the sequencer is the slave.
interface control_flow_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int TAG_W  = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        opcode;
  logic [ADDR_W-1:0] imm;
  logic [ADDR_W-1:0] cont_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              has_result;
  logic              cond;
  logic [ADDR_W-1:0] pc_next;
  logic [TAG_W-1:0]  cur_tag;

  modport master (
    output instr_valid, opcode, imm, cont_addr, end_addr, has_result, cond, pc_next, cur_tag,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, opcode, imm, cont_addr, end_addr, has_result, cond, pc_next, cur_tag,
    output instr_ready
  );
endinterface

// File: rtl/control_flow_sequencer.sv
// WASM structured-control sequencer: drives control-stack strobes, frame words and PC loads.
// Optional stack-depth guard enabled by defining CF_DEPTH_CHECK_EN.
module control_flow_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TAG_W   = 4,
  parameter int LBL_W   = 4,
`ifdef CF_DEPTH_CHECK_EN
  parameter int DEPTH   = 16,
`endif
  parameter int FRAME_W = 3 + TAG_W + ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  control_flow_sequencer_if.slave instr,
  output logic                cs_push,
  output logic                cs_pop,
  output logic                cs_return,
  output logic                cs_function_call,
  output logic [FRAME_W-1:0]  cs_push_data,
  input  logic [FRAME_W-1:0]  cs_top_data,
  input  logic                cs_left_one,
  output logic                pc_load,
  output logic [ADDR_W-1:0]   pc_target,
  output logic                tag_restore_valid,
  output logic [TAG_W-1:0]    tag_restore,
  output logic                halt,
  output logic                err
);

  localparam logic [7:0] OP_BLOCK  = 8'h02;
  localparam logic [7:0] OP_LOOP   = 8'h03;
  localparam logic [7:0] OP_IF     = 8'h04;
  localparam logic [7:0] OP_ELSE   = 8'h05;
  localparam logic [7:0] OP_END    = 8'h0B;
  localparam logic [7:0] OP_BR     = 8'h0C;
  localparam logic [7:0] OP_BR_IF  = 8'h0D;
  localparam logic [7:0] OP_RETURN = 8'h0F;
  localparam logic [7:0] OP_CALL   = 8'h10;

  localparam logic [1:0] FT_BLOCK = 2'b00;
  localparam logic [1:0] FT_CALL  = 2'b01;
  localparam logic [1:0] FT_IF    = 2'b10;
  localparam logic [1:0] FT_LOOP  = 2'b11;

  typedef enum logic [1:0] {ST_IDLE, ST_UNWIND, ST_TARGET} state_t;

  state_t             state_r;
  logic [LBL_W-1:0]   cnt_r;
  logic               halt_r;
  logic               err_r;

  logic               ready_s;
  logic               accept_s;
  logic [1:0]         top_type_s;
  logic [TAG_W-1:0]   top_tag_s;
  logic [ADDR_W-1:0]  top_extra_s;
  logic [LBL_W-1:0]   lbl_s;

  logic               push_raw_s;
  logic               pop_raw_s;
  logic               ret_raw_s;
  logic               call_raw_s;
  logic               load_raw_s;
  logic               restore_raw_s;
  logic [FRAME_W-1:0] push_data_s;
  logic [ADDR_W-1:0]  target_s;
  logic               halt_set_s;
  logic               err_set_s;
  logic               br_go_s;
  logic               guard_s;
  logic               err_any_s;
  logic               unused_s;

  function automatic logic [FRAME_W-1:0] make_frame(
    input logic [1:0]        ftype,
    input logic              retu,
    input logic [TAG_W-1:0]  tag,
    input logic [ADDR_W-1:0] extra
  );
    return {ftype, retu, tag, extra};
  endfunction

  assign top_type_s  = cs_top_data[FRAME_W-1 -: 2];
  assign top_tag_s   = cs_top_data[ADDR_W +: TAG_W];
  assign top_extra_s = cs_top_data[ADDR_W-1:0];
  assign lbl_s       = instr.imm[LBL_W-1:0];
  assign unused_s    = cs_top_data[FRAME_W-3];

  assign ready_s           = (state_r == ST_IDLE) & ~halt_r & rst_n;
  assign accept_s          = instr.instr_valid & ready_s;
  assign instr.instr_ready = ready_s;

  // Decode the current instruction or FSM step into raw stack/PC actions.
  always_comb begin
    push_raw_s    = 1'b0;
    pop_raw_s     = 1'b0;
    ret_raw_s     = 1'b0;
    call_raw_s    = 1'b0;
    load_raw_s    = 1'b0;
    restore_raw_s = 1'b0;
    push_data_s   = {FRAME_W{1'b0}};
    target_s      = {ADDR_W{1'b0}};
    halt_set_s    = 1'b0;
    err_set_s     = 1'b0;
    br_go_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          case (instr.opcode)
            OP_BLOCK: begin
              push_raw_s  = 1'b1;
              push_data_s = make_frame(FT_BLOCK, instr.has_result, instr.cur_tag, instr.cont_addr);
            end
            OP_LOOP: begin
              push_raw_s  = 1'b1;
              push_data_s = make_frame(FT_LOOP, instr.has_result, instr.cur_tag, instr.pc_next);
            end
            OP_IF: begin
              push_raw_s  = 1'b1;
              push_data_s = make_frame(FT_IF, instr.has_result, instr.cur_tag, instr.end_addr);
              load_raw_s  = ~instr.cond;
              target_s    = instr.cont_addr;
            end
            OP_ELSE: begin
              pop_raw_s  = 1'b1;
              load_raw_s = 1'b1;
              target_s   = top_extra_s;
            end
            OP_END: begin
              pop_raw_s     = 1'b1;
              load_raw_s    = (top_type_s == FT_CALL);
              restore_raw_s = (top_type_s == FT_CALL);
              target_s      = top_extra_s;
              halt_set_s    = cs_left_one;
            end
            OP_CALL: begin
              push_raw_s  = 1'b1;
              call_raw_s  = 1'b1;
              push_data_s = make_frame(FT_CALL, instr.has_result, instr.cur_tag, instr.pc_next);
              load_raw_s  = 1'b1;
              target_s    = instr.imm;
            end
            OP_RETURN: begin
              ret_raw_s     = 1'b1;
              pop_raw_s     = 1'b1;
              load_raw_s    = 1'b1;
              restore_raw_s = 1'b1;
              target_s      = top_extra_s;
            end
            OP_BR:    br_go_s = 1'b1;
            OP_BR_IF: br_go_s = instr.cond;
            default:  br_go_s = 1'b0;
          endcase
        end else begin
          br_go_s = 1'b0;
        end
      end
      ST_UNWIND: begin
        // A branch must never unwind past the enclosing function's call frame.
        if (top_type_s == FT_CALL) begin
          err_set_s = 1'b1;
        end else begin
          pop_raw_s = 1'b1;
        end
      end
      ST_TARGET: begin
        target_s = top_extra_s;
        case (top_type_s)
          FT_LOOP:  load_raw_s = 1'b1;
          FT_BLOCK,
          FT_IF: begin
            pop_raw_s  = 1'b1;
            load_raw_s = 1'b1;
          end
          FT_CALL:  err_set_s = 1'b1;
          default:  err_set_s = 1'b1;
        endcase
      end
      default: err_set_s = 1'b0;
    endcase
  end

`ifdef CF_DEPTH_CHECK_EN
  localparam int DEP_W = $clog2(DEPTH) + 1;
  localparam int SH_N  = 4;

  logic [DEP_W-1:0] depth_r;
  logic [DEP_W-1:0] shadow_r [SH_N];
  logic [2:0]       sp_r;

  // Block a push onto a full stack or any pop from an empty one.
  always_comb begin
    guard_s = (push_raw_s & (depth_r == DEP_W'(DEPTH))) |
              (pop_raw_s & (depth_r == {DEP_W{1'b0}}));
  end

  // Track stack depth; the shadow LIFO remembers the caller depth for return.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      depth_r <= {DEP_W{1'b0}};
      sp_r    <= 3'd0;
      for (int i = 0; i < SH_N; i++) begin
        shadow_r[i] <= {DEP_W{1'b0}};
      end
    end else if (guard_s) begin
      depth_r <= depth_r;
    end else if (ret_raw_s) begin
      if (sp_r != 3'd0) begin
        depth_r <= shadow_r[2'(sp_r - 3'd1)];
        sp_r    <= sp_r - 3'd1;
      end else begin
        depth_r <= {DEP_W{1'b0}};
      end
    end else if (call_raw_s) begin
      if (sp_r != 3'(SH_N)) begin
        shadow_r[2'(sp_r)] <= depth_r;
        sp_r               <= sp_r + 3'd1;
      end else begin
        sp_r <= sp_r;
      end
      depth_r <= depth_r + DEP_W'(1);
    end else if (push_raw_s) begin
      depth_r <= depth_r + DEP_W'(1);
    end else if (pop_raw_s) begin
      depth_r <= depth_r - DEP_W'(1);
      if (restore_raw_s && (sp_r != 3'd0)) begin
        sp_r <= sp_r - 3'd1;
      end else begin
        sp_r <= sp_r;
      end
    end else begin
      depth_r <= depth_r;
    end
  end
`else
  assign guard_s = 1'b0;
`endif

  assign err_any_s         = err_set_s | guard_s;
  assign cs_push           = push_raw_s & ~guard_s;
  assign cs_pop            = pop_raw_s & ~guard_s;
  assign cs_return         = ret_raw_s & ~guard_s;
  assign cs_function_call  = call_raw_s & ~guard_s;
  assign cs_push_data      = push_data_s;
  assign pc_load           = load_raw_s & ~guard_s;
  assign pc_target         = target_s;
  assign tag_restore_valid = restore_raw_s & ~guard_s;
  assign tag_restore       = top_tag_s;
  assign halt              = halt_r;
  assign err               = err_r;

  // Branch FSM with sticky halt/err flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {LBL_W{1'b0}};
      halt_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      halt_r <= halt_r | (halt_set_s & ~guard_s);
      err_r  <= err_r | err_any_s;
      case (state_r)
        ST_IDLE: begin
          if (br_go_s) begin
            cnt_r   <= lbl_s;
            state_r <= (lbl_s == {LBL_W{1'b0}}) ? ST_TARGET : ST_UNWIND;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_UNWIND: begin
          if (err_any_s) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r   <= cnt_r - LBL_W'(1);
            state_r <= (cnt_r == LBL_W'(1)) ? ST_TARGET : ST_UNWIND;
          end
        end
        ST_TARGET: state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_control_flow_sequencer.sv
// Directed bench for control_flow_sequencer; a queue models the control stack
// so the top-of-stack view follows the sequencer's strobes.
module tb_control_flow_sequencer;

  localparam logic [7:0] OP_NOP    = 8'h01;
  localparam logic [7:0] OP_BLOCK  = 8'h02;
  localparam logic [7:0] OP_LOOP   = 8'h03;
  localparam logic [7:0] OP_IF     = 8'h04;
  localparam logic [7:0] OP_END    = 8'h0B;
  localparam logic [7:0] OP_BR     = 8'h0C;
  localparam logic [7:0] OP_BR_IF  = 8'h0D;
  localparam logic [7:0] OP_RETURN = 8'h0F;
  localparam logic [7:0] OP_CALL   = 8'h10;

  logic        clk;
  logic        rst_n;
  logic        cs_push, cs_pop, cs_return, cs_function_call;
  logic [14:0] cs_push_data;
  logic [14:0] cs_top_data;
  logic        cs_left_one;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic        tag_restore_valid;
  logic [3:0]  tag_restore;
  logic        halt, err;

  logic [14:0] stk[$];
  int          n_run;
  int          n_fail;
  int          low_cnt;

  logic        o_ready, o_push, o_pop, o_ret, o_call, o_load, o_rv, o_halt, o_err;
  logic [14:0] o_data;
  logic [7:0]  o_target;
  logic [3:0]  o_tag;

  control_flow_sequencer_if #(.ADDR_W(8), .TAG_W(4)) ifc ();

  control_flow_sequencer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .instr             (ifc.slave),
    .cs_push           (cs_push),
    .cs_pop            (cs_pop),
    .cs_return         (cs_return),
    .cs_function_call  (cs_function_call),
    .cs_push_data      (cs_push_data),
    .cs_top_data       (cs_top_data),
    .cs_left_one       (cs_left_one),
    .pc_load           (pc_load),
    .pc_target         (pc_target),
    .tag_restore_valid (tag_restore_valid),
    .tag_restore       (tag_restore),
    .halt              (halt),
    .err               (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic view(input bit ret_view);
    cs_top_data = 15'h0000;
    if (stk.size() > 0) cs_top_data = stk[stk.size()-1];
    if (ret_view) begin
      for (int i = stk.size() - 1; i >= 0; i--) begin
        if (stk[i][14:13] == 2'b01) begin
          cs_top_data = stk[i];
          break;
        end
      end
    end
    cs_left_one = (stk.size() == 1);
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic [7:0] im,
                       input logic [7:0] ca, input logic [7:0] ea, input logic hr,
                       input logic cd, input logic [7:0] pn, input logic [3:0] tg);
    logic [14:0] f;
    @(negedge clk);
    ifc.instr_valid = v;
    ifc.opcode      = op;
    ifc.imm         = im;
    ifc.cont_addr   = ca;
    ifc.end_addr    = ea;
    ifc.has_result  = hr;
    ifc.cond        = cd;
    ifc.pc_next     = pn;
    ifc.cur_tag     = tg;
    view(v && (op == OP_RETURN));
    #1;
    o_ready  = ifc.instr_ready;
    o_push   = cs_push;
    o_pop    = cs_pop;
    o_ret    = cs_return;
    o_call   = cs_function_call;
    o_data   = cs_push_data;
    o_load   = pc_load;
    o_target = pc_target;
    o_rv     = tag_restore_valid;
    o_tag    = tag_restore;
    o_halt   = halt;
    o_err    = err;
    if (o_ret) begin
      while (stk.size() > 0) begin
        f = stk.pop_back();
        if (f[14:13] == 2'b01) break;
      end
    end else if (o_pop && (stk.size() > 0)) begin
      f = stk.pop_back();
    end
    if (o_push) stk.push_back(o_data);
  endtask

  task automatic ins(input logic [7:0] op, input logic [7:0] im, input logic [7:0] ca,
                     input logic [7:0] ea, input logic hr, input logic cd,
                     input logic [7:0] pn, input logic [3:0] tg);
    drive(1'b1, op, im, ca, ea, hr, cd, pn, tg);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0);
  endtask

  task automatic do_reset();
    ifc.instr_valid = 1'b0;
    rst_n = 1'b0;
    stk.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_run = 0;
    n_fail = 0;
    ifc.instr_valid = 1'b0;
    ifc.opcode = 8'h00; ifc.imm = 8'h00; ifc.cont_addr = 8'h00; ifc.end_addr = 8'h00;
    ifc.has_result = 1'b0; ifc.cond = 1'b0; ifc.pc_next = 8'h00; ifc.cur_tag = 4'h0;
    cs_top_data = 15'h0000;
    cs_left_one = 1'b0;
    rst_n = 1'b0;
    #12;
    chk("rst_ready", {31'd0, ifc.instr_ready}, 32'd0);
    chk("rst_flags", {30'd0, halt, err}, 32'd0);
    chk("rst_strobes", {28'd0, cs_push, cs_pop, cs_return, pc_load}, 32'd0);
    do_reset();

    // Base function-body frame, then call / end.
    ins(OP_BLOCK, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b0, 8'h01, 4'h0);
    chk("base_push", {17'd0, o_push, o_data}, {17'd0, 1'b1, 15'h007F});
    ins(OP_CALL, 8'h40, 8'h00, 8'h00, 1'b1, 1'b0, 8'h11, 4'h3);
    chk("call_strobes", {28'd0, o_push, o_call, o_pop, o_load}, {28'd0, 4'b1101});
    chk("call_data", {17'd0, o_data}, 32'h3311);
    chk("call_target", {24'd0, o_target}, 32'h40);
    ins(OP_END, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0);
    chk("fend_strobes", {28'd0, o_pop, o_push, o_load, o_rv}, {28'd0, 4'b1011});
    chk("fend_target", {20'd0, o_tag, o_target}, {20'd0, 4'h3, 8'h11});
    chk("fend_halt", {31'd0, o_halt}, 32'd0);

    // block / loop / if, then br 2.
    ins(OP_BLOCK, 8'h00, 8'h20, 8'h00, 1'b0, 1'b0, 8'h03, 4'h5);
    chk("block_data", {17'd0, o_data}, 32'h0520);
    ins(OP_LOOP, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 8'h08, 4'h5);
    chk("loop_data", {17'd0, o_data}, 32'h7508);
    ins(OP_IF, 8'h00, 8'h44, 8'h30, 1'b0, 1'b1, 8'h0A, 4'h5);
    chk("if_true", {17'd0, o_push, o_load, o_data[14:13], o_data[7:0], 5'd0},
        {17'd0, 1'b1, 1'b0, 2'b10, 8'h30, 5'd0});
    ins(OP_BR, 8'h02, 8'h00, 8'h00, 1'b0, 1'b0, 8'h0B, 4'h5);
    chk("br_accept", {29'd0, o_ready, o_push, o_pop}, {29'd0, 3'b100});
    low_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      idle();
      if (o_ready) break;
      low_cnt++;
      if (c < 2) chk("unwind_pop", {30'd0, o_pop, o_load}, {30'd0, 2'b10});
      if (c == 2) chk("target_block", {22'd0, o_pop, o_load, o_target}, {22'd0, 2'b11, 8'h20});
    end
    chk("br_busy_cycles", low_cnt, 32'd3);
    chk("br_depth", stk.size(), 32'd1);

    // loop then br_if 0 taken / not taken; unknown opcode.
    ins(OP_LOOP, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h05, 4'h1);
    ins(OP_BR_IF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h06, 4'h1);
    idle();
    chk("brif_target", {22'd0, o_pop, o_load, o_target}, {22'd0, 2'b01, 8'h05});
    chk("brif_depth", stk.size(), 32'd2);
    ins(OP_BR_IF, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h06, 4'h1);
    chk("brif_nt", {28'd0, o_push, o_pop, o_load, o_ready}, {28'd0, 4'b0001});
    idle();
    chk("brif_nt_next", {30'd0, o_ready, o_load}, {30'd0, 2'b10});
    ins(OP_NOP, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0);
    chk("nop", {28'd0, o_ready, o_push, o_pop, o_load}, {28'd0, 4'b1000});
    ins(OP_END, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0);

    // if with cond=0 jumps to the false path; its end is a plain pop.
    ins(OP_IF, 8'h00, 8'h14, 8'h40, 1'b0, 1'b0, 8'h0C, 4'h2);
    chk("if_false", {22'd0, o_push, o_load, o_target}, {22'd0, 2'b11, 8'h14});
    ins(OP_END, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0);
    chk("if_end", {29'd0, o_pop, o_load, o_rv}, {29'd0, 3'b100});

    // call, block, block, return, then the final end halts.
    ins(OP_CALL, 8'h60, 8'h00, 8'h00, 1'b0, 1'b0, 8'h22, 4'h7);
    ins(OP_BLOCK, 8'h00, 8'h50, 8'h00, 1'b0, 1'b0, 8'h23, 4'h8);
    ins(OP_BLOCK, 8'h00, 8'h51, 8'h00, 1'b0, 1'b0, 8'h24, 4'h9);
    ins(OP_RETURN, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h25, 4'h9);
    chk("ret_strobes", {27'd0, o_ret, o_pop, o_push, o_load, o_rv}, {27'd0, 5'b11011});
    chk("ret_target", {20'd0, o_tag, o_target}, {20'd0, 4'h7, 8'h22});
    chk("ret_depth", stk.size(), 32'd1);
    ins(OP_END, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0);
    chk("final_end", {30'd0, o_pop, o_load}, {30'd0, 2'b10});
    ins(OP_BLOCK, 8'h00, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 4'h0);
    chk("halted", {29'd0, o_halt, o_ready, o_push}, {29'd0, 3'b100});

    do_reset();
    idle();
    chk("halt_cleared", {30'd0, o_halt, o_ready}, {30'd0, 2'b01});

    // br 1 inside a call with no enclosing block must flag err, not pop.
    ins(OP_BLOCK, 8'h00, 8'h7F, 8'h00, 1'b0, 1'b0, 8'h01, 4'h0);
    ins(OP_CALL, 8'h30, 8'h00, 8'h00, 1'b0, 1'b0, 8'h02, 4'h1);
    ins(OP_BR, 8'h01, 8'h00, 8'h00, 1'b0, 1'b0, 8'h31, 4'h1);
    idle();
    chk("br_call_nopop", {30'd0, o_pop, o_ready}, {30'd0, 2'b00});
    idle();
    chk("br_call_err", {30'd0, o_err, o_ready}, {30'd0, 2'b11});
    chk("br_call_depth", stk.size(), 32'd2);

    // Reset in the middle of a br 3 unwind.
    ins(OP_BLOCK, 8'h00, 8'h40, 8'h00, 1'b0, 1'b0, 8'h32, 4'h1);
    ins(OP_BLOCK, 8'h00, 8'h41, 8'h00, 1'b0, 1'b0, 8'h33, 4'h1);
    ins(OP_BLOCK, 8'h00, 8'h42, 8'h00, 1'b0, 1'b0, 8'h34, 4'h1);
    ins(OP_BR, 8'h03, 8'h00, 8'h00, 1'b0, 1'b0, 8'h35, 4'h1);
    idle();
    chk("mid_unwind_pop", {30'd0, o_pop, o_ready}, {30'd0, 2'b10});
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {29'd0, err, halt, cs_pop}, {29'd0, 3'b000});
    stk.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("post_rst_idle", {29'd0, o_ready, o_pop, o_err}, {29'd0, 3'b100});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
